r4_car_queue_counter: RTL and testbench

//  Vehicle-queue tracker for road 4. Produces the car count that feeds the traffic-light
//  FSM's i_r4_car_cnt input. It consumes the raw road-4 loop-sensor signal and the FSM's

---
 rtl/r4_car_queue_counter_if.sv | 36 +++
 rtl/r4_car_queue_counter.sv | 178 +++++++++++++++++
 tb/tb_r4_car_queue_counter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/r4_car_queue_counter_if.sv
// Signal bundle between the road-4 queue counter and its environment: loop sensor
// and light-FSM status in, queue count and status flags out.
interface r4_car_queue_counter_if #(
  parameter int CNT_W = 4
);
  logic             i_car_sense;
  logic             i_r4_green_l;
  logic             i_r4_red;
  logic [CNT_W-1:0] o_r4_car_cnt;
  logic             o_arrive_pulse;
  logic             o_full;
  logic             o_ovf;
  logic             o_light_err;

  modport master (
    output i_car_sense,
    output i_r4_green_l,
    output i_r4_red,
    input  o_r4_car_cnt,
    input  o_arrive_pulse,
    input  o_full,
    input  o_ovf,
    input  o_light_err
  );

  modport slave (
    input  i_car_sense,
    input  i_r4_green_l,
    input  i_r4_red,
    output o_r4_car_cnt,
    output o_arrive_pulse,
    output o_full,
    output o_ovf,
    output o_light_err
  );
endinterface

// File: rtl/r4_car_queue_counter.sv
// Road-4 vehicle queue tracker: debounces the loop sensor into arrivals and retires
// one car per DEPART_CYC cycles of left-turn green.
//
// state     | meaning
// S_IDLE    | loop empty, waiting for a synchronised high
// S_RISE    | sensor high, counting samples before accepting a car
// S_PRESENT | car accepted and still over the loop
// S_FALL    | sensor low, counting samples before declaring the loop empty
module r4_car_queue_counter #(
  parameter int CNT_W        = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int DEPART_CYC   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  r4_car_queue_counter_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int DP_W = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DEBOUNCE_CYC);
  localparam logic [DP_W-1:0]  DP_TERM  = DP_W'(DEPART_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RISE    = 2'd1,
    S_PRESENT = 2'd2,
    S_FALL    = 2'd3
  } state_t;

  // Reset asserts immediately but releases only on a clock edge.
  logic rst_meta_q;
  logic rst_sync_q;
  logic rst_int_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  logic sense_meta_q;
  logic sense_s_q;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sense_meta_q <= 1'b0;
      sense_s_q    <= 1'b0;
    end else begin
      sense_meta_q <= bus.i_car_sense;
      sense_s_q    <= sense_meta_q;
    end
  end

  state_t          state_q;
  state_t          state_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            arrive;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= S_IDLE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    arrive   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sense_s_q) begin
          state_d  = S_RISE;
          db_cnt_d = DB_W'(1);
        end
      end
      S_RISE: begin
        if (!sense_s_q) begin
          state_d = S_IDLE;
        end else if (db_cnt_q == DB_TERM) begin
          state_d = S_PRESENT;
          arrive  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      S_PRESENT: begin
        if (!sense_s_q) begin
          state_d  = S_FALL;
          db_cnt_d = DB_W'(1);
        end
      end
      S_FALL: begin
        if (sense_s_q) begin
          state_d = S_PRESENT;
        end else if (db_cnt_q == DB_TERM) begin
          state_d = S_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [DP_W-1:0]  dp_cnt_q;
  logic [DP_W-1:0]  dp_cnt_d;
  logic             dp_en;
  logic             depart;
  logic             light_clash;

  // A red/green clash blocks departures; the non-zero guard rules out underflow.
  assign light_clash = bus.i_r4_red & bus.i_r4_green_l;
  assign dp_en       = bus.i_r4_green_l & ~bus.i_r4_red & (cnt_q != '0);
  assign depart      = dp_en & (dp_cnt_q == DP_TERM);
  assign dp_cnt_d    = (dp_en && !depart) ? dp_cnt_q + DP_W'(1) : '0;

  logic ovf_q;
  logic ovf_d;
  logic err_q;
  logic err_d;
  logic pulse_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    err_d = err_q | light_clash;
    if (arrive && !depart) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (depart && !arrive) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q    <= '0;
      dp_cnt_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dp_cnt_q <= dp_cnt_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      pulse_q  <= arrive;
    end
  end

  assign bus.o_r4_car_cnt   = cnt_q;
  assign bus.o_arrive_pulse = pulse_q;
  assign bus.o_full         = (cnt_q == CNT_MAX);
  assign bus.o_ovf          = ovf_q;
  assign bus.o_light_err    = err_q;

endmodule

// File: tb/tb_r4_car_queue_counter.sv
// Bench for the road-4 queue counter: directed scenarios plus random sensor/light
// traffic compared every cycle against an event-level queue model.
module tb_r4_car_queue_counter;

  localparam int CNT_W = 4;
  localparam int DB    = 4;
  localparam int DP    = 5;
  localparam int CMAX  = 15;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;

  r4_car_queue_counter_if #(.CNT_W(CNT_W)) bus();

  r4_car_queue_counter #(
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DB),
    .DEPART_CYC  (DP)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #10 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: a car is accepted once DB+1 high samples are seen while the loop
  // is considered empty; the loop empties after DB+1 low samples. The accepted car is
  // registered two edges later (synchroniser delay). Each run of DP eligible green
  // cycles retires one car.
  int m_hi = 0, m_lo = 0, m_run = 0, m_cnt = 0;
  bit m_present = 0, m_p0 = 0, m_p1 = 0, m_pulse = 0, m_ovf = 0, m_err = 0;
  bit m_det, m_clear, m_elig, m_dep;

  always_comb begin
    m_det   = bus.i_car_sense && !m_present && (m_hi + 1 == DB + 1);
    m_clear = !bus.i_car_sense && m_present && (m_lo + 1 == DB + 1);
    m_elig  = bus.i_r4_green_l && !bus.i_r4_red && (m_cnt > 0);
    m_dep   = m_elig && (m_run + 1 == DP);
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_hi <= 0; m_lo <= 0; m_run <= 0; m_cnt <= 0;
      m_present <= 0; m_p0 <= 0; m_p1 <= 0; m_pulse <= 0; m_ovf <= 0; m_err <= 0;
    end else begin
      m_hi <= bus.i_car_sense ? ((m_hi < 100) ? m_hi + 1 : m_hi) : 0;
      m_lo <= bus.i_car_sense ? 0 : ((m_lo < 100) ? m_lo + 1 : m_lo);
      if (m_det) m_present <= 1;
      else if (m_clear) m_present <= 0;
      m_p0    <= m_det;
      m_p1    <= m_p0;
      m_pulse <= m_p1;
      m_run   <= (m_elig && !m_dep) ? m_run + 1 : 0;
      if (m_p1 && !m_dep) begin
        if (m_cnt == CMAX) m_ovf <= 1;
        else m_cnt <= m_cnt + 1;
      end else if (m_dep && !m_p1) begin
        m_cnt <= m_cnt - 1;
      end
      if (bus.i_r4_red && bus.i_r4_green_l) m_err <= 1;
    end
  end

  bit mon_en = 0;

  always @(negedge i_clk) begin
    if (mon_en && i_rst_n) begin
      chk("mdl_cnt",   int'(bus.o_r4_car_cnt),   m_cnt);
      chk("mdl_pulse", int'(bus.o_arrive_pulse), int'(m_pulse));
      chk("mdl_full",  int'(bus.o_full),         int'(m_cnt == CMAX));
      chk("mdl_ovf",   int'(bus.o_ovf),          int'(m_ovf));
      chk("mdl_err",   int'(bus.o_light_err),    int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    bus.i_car_sense = 1'b0; bus.i_r4_green_l = 1'b0; bus.i_r4_red = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic arrive_car();
    bus.i_car_sense = 1'b1;
    cyc(6);
    bus.i_car_sense = 1'b0;
    cyc(7);
  endtask

  task automatic rnd_cycle();
    if ($urandom_range(0, 7) == 0) bus.i_r4_green_l = !bus.i_r4_green_l;
    bus.i_r4_red = ($urandom_range(0, 149) == 0);
    @(negedge i_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p;
    int first;
    bus.i_car_sense = 1'b0; bus.i_r4_green_l = 1'b0; bus.i_r4_red = 1'b0;
    #5 i_rst_n = 1'b0;

    // reset values
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1);
    chk("rst_cnt",   int'(bus.o_r4_car_cnt),   0);
    chk("rst_pulse", int'(bus.o_arrive_pulse), 0);
    chk("rst_full",  int'(bus.o_full),         0);
    chk("rst_ovf",   int'(bus.o_ovf),          0);
    chk("rst_err",   int'(bus.o_light_err),    0);
    cyc(3);
    mon_en = 1;

    // asynchronous reset while holding 5 cars
    repeat (5) arrive_car();
    chk("pre_rst_cnt", int'(bus.o_r4_car_cnt), 5);
    #7 i_rst_n = 1'b0;
    #1 chk("async_rst_cnt", int'(bus.o_r4_car_cnt), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(4);

    // short glitch is rejected
    p = 0;
    bus.i_car_sense = 1'b1;
    cyc(3);
    bus.i_car_sense = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (bus.o_arrive_pulse) p++;
    end
    chk("glitch_pulses", p, 0);
    chk("glitch_cnt", int'(bus.o_r4_car_cnt), 0);

    // long press: exactly one pulse, on edge DB+3
    p = 0; first = 0;
    bus.i_car_sense = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge i_clk);
      if (e == 10) bus.i_car_sense = 1'b0;
      if (bus.o_arrive_pulse) begin
        p++;
        if (first == 0) first = e;
      end
    end
    chk("arrive_edge", first, 7);
    chk("arrive_pulses", p, 1);
    cyc(8);
    chk("arrive_cnt", int'(bus.o_r4_car_cnt), 1);

    // departures every DP edges of green
    reset_dut();
    repeat (3) arrive_car();
    chk("dep_start_cnt", int'(bus.o_r4_car_cnt), 3);
    bus.i_r4_green_l = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge i_clk);
      if (e == 4)  chk("dep_e4",  int'(bus.o_r4_car_cnt), 3);
      if (e == 5)  chk("dep_e5",  int'(bus.o_r4_car_cnt), 2);
      if (e == 10) chk("dep_e10", int'(bus.o_r4_car_cnt), 1);
      if (e == 15) chk("dep_e15", int'(bus.o_r4_car_cnt), 0);
      if (e == 20) chk("dep_e20", int'(bus.o_r4_car_cnt), 0);
    end
    bus.i_r4_green_l = 1'b0;
    cyc(2);

    // saturation and overflow
    reset_dut();
    repeat (15) arrive_car();
    chk("sat_cnt15",  int'(bus.o_r4_car_cnt), 15);
    chk("sat_full",   int'(bus.o_full),       1);
    chk("sat_noovf",  int'(bus.o_ovf),        0);
    arrive_car();
    chk("ovf_set",    int'(bus.o_ovf),        1);
    chk("ovf_cnt",    int'(bus.o_r4_car_cnt), 15);
    chk("ovf_full",   int'(bus.o_full),       1);

    // arrival coincident with departure
    reset_dut();
    repeat (2) arrive_car();
    bus.i_car_sense = 1'b1;
    cyc(2);
    bus.i_r4_green_l = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge i_clk);
      if (e == 4) bus.i_car_sense = 1'b0;
      if (e == 5) begin
        chk("coin_pulse", int'(bus.o_arrive_pulse), 1);
        chk("coin_cnt",   int'(bus.o_r4_car_cnt),   2);
      end
      if (e == 10) chk("coin_next_dep", int'(bus.o_r4_car_cnt), 1);
    end
    bus.i_r4_green_l = 1'b0;
    chk("coin_noovf", int'(bus.o_ovf), 0);
    cyc(4);

    // red and green together
    reset_dut();
    repeat (4) arrive_car();
    chk("clash_pre_err", int'(bus.o_light_err), 0);
    bus.i_r4_red = 1'b1; bus.i_r4_green_l = 1'b1;
    cyc(6);
    bus.i_r4_red = 1'b0; bus.i_r4_green_l = 1'b0;
    cyc(1);
    chk("clash_err", int'(bus.o_light_err),  1);
    chk("clash_cnt", int'(bus.o_r4_car_cnt), 4);

    // random traffic against the model
    reset_dut();
    for (int s = 0; s < 150; s++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(1, 10));
      lo = int'($urandom_range(1, 12));
      bus.i_car_sense = 1'b1;
      repeat (hi) rnd_cycle();
      bus.i_car_sense = 1'b0;
      repeat (lo) rnd_cycle();
    end
    bus.i_r4_green_l = 1'b0; bus.i_r4_red = 1'b0;
    cyc(10);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
